// File: rtl/server_seq_pkg.sv
// Shared types for the server operation sequencer: opcodes, FSM states,
// flag-vector bit positions and the per-opcode terminal counts of the counter.
package server_seq_pkg;

    localparam int FLAG_W = 11;

    // Bit positions inside the operation flag vector
    localparam int F_DECODE   = 0;
    localparam int F_ACCUM    = 1;
    localparam int F_DECRYPT  = 2;
    localparam int F_NO_NTT   = 3;
    localparam int F_PK_SK    = 4;
    localparam int F_SK_PK    = 5;
    localparam int F_EP_ACC   = 6;
    localparam int F_EP_GEN   = 7;
    localparam int F_EXTR_MUL = 8;
    localparam int F_INTT     = 9;
    localparam int F_NTT      = 10;

    typedef enum logic [3:0] {
        OP_DECODE   = 4'd0,
        OP_ACCUM    = 4'd1,
        OP_DECRYPT  = 4'd2,
        OP_PK_SK    = 4'd3,
        OP_SK_PK    = 4'd4,
        OP_EP_ACC   = 4'd5,
        OP_EP_GEN   = 4'd6,
        OP_EXTR_MUL = 4'd7,
        OP_INTT     = 4'd8,
        OP_NTT      = 4'd9,
        OP_KEYGEN   = 4'd10
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_RUN   = 2'd2,
        S_DRAIN = 2'd3
    } state_e;

    // Counter terminal counts per opcode, used by benches driving op_done
    function automatic int unsigned term_count(input logic [3:0] op);
        case (op)
            OP_DECODE:   term_count = 64;
            OP_ACCUM:    term_count = 643;
            OP_DECRYPT:  term_count = 65;
            OP_PK_SK:    term_count = 576;
            OP_SK_PK:    term_count = 131;
            OP_EP_ACC:   term_count = 99;
            OP_EP_GEN:   term_count = 99;
            OP_EXTR_MUL: term_count = 583;
            OP_INTT:     term_count = 199;
            OP_NTT:      term_count = 198;
            default:     term_count = 64;
        endcase
    endfunction

endpackage

// File: rtl/server_op_decode.sv
// Combinational opcode decoder: maps a 4-bit opcode onto the one-hot-ish
// operation flag vector and flags opcodes outside the legal range.
module server_op_decode
    import server_seq_pkg::*;
(
    input  logic [3:0]        op,
    output logic [FLAG_W-1:0] flags,
    output logic              legal
);

    // Opcode to flag pattern; KEYGEN is legal but drives no flags
    always_comb begin
        flags = '0;
        legal = 1'b1;
        case (op)
            OP_DECODE:   flags[F_DECODE]   = 1'b1;
            OP_ACCUM:    flags[F_ACCUM]    = 1'b1;
            OP_DECRYPT: begin
                flags[F_DECRYPT] = 1'b1;
                flags[F_NO_NTT]  = 1'b1;
            end
            OP_PK_SK:    flags[F_PK_SK]    = 1'b1;
            OP_SK_PK:    flags[F_SK_PK]    = 1'b1;
            OP_EP_ACC: begin
                flags[F_EP_ACC] = 1'b1;
                flags[F_EP_GEN] = 1'b1;
            end
            OP_EP_GEN:   flags[F_EP_GEN]   = 1'b1;
            OP_EXTR_MUL: flags[F_EXTR_MUL] = 1'b1;
            OP_INTT:     flags[F_INTT]     = 1'b1;
            OP_NTT:      flags[F_NTT]      = 1'b1;
            OP_KEYGEN:   flags = '0;
            default:     legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/server_op_sequencer.sv
// Server operation sequencer: accepts one opcode at a time, drives the
// registered operation flags, runs the server counter until op_done, then
// pulses seq_done. Optional RUN watchdog is built when SEQ_TIMEOUT_EN is defined.
module server_op_sequencer
    import server_seq_pkg::*;
#(
    parameter int TO_W    = 10,
    parameter int TIMEOUT = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cmd_valid,
    input  logic [3:0] cmd_op,
    output logic cmd_ready,
    input  logic abort,
    input  logic op_done,
    output logic server_counter_start,
    output logic decode_start,
    output logic accumulate_start,
    output logic decrypt_start,
    output logic no_ntt,
    output logic mem_pk_sk_transfer,
    output logic mem_sk_pk_transfer,
    output logic ep_accumulate,
    output logic ep_gen,
    output logic extr_mul,
    output logic intt_start,
    output logic ntt_start_out,
    output logic seq_busy,
    output logic seq_done,
    output logic seq_err
);

    // The watchdog must outlast the longest operation and fit its counter
    if (TIMEOUT <= 643 || TIMEOUT > (1 << TO_W)) begin : g_bad_cfg
        $error("server_op_sequencer: TIMEOUT must exceed 643 and fit in TO_W bits");
    end

    state_e            state, next_state;
    logic [FLAG_W-1:0] dec_flags;
    logic              dec_legal;
    logic [FLAG_W-1:0] flags_q;
    logic              err_set;
    logic              wd_hit;

    server_op_decode u_decode (
        .op    (cmd_op),
        .flags (dec_flags),
        .legal (dec_legal)
    );

`ifdef SEQ_TIMEOUT_EN
    logic [TO_W-1:0] wd_cnt;

    // Watchdog: zero outside RUN, so it reads 0 in the first RUN cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wd_cnt <= '0;
        else if (state != S_RUN)
            wd_cnt <= '0;
        else
            wd_cnt <= wd_cnt + 1'b1;
    end

    assign wd_hit = (state == S_RUN) && (wd_cnt == TO_W'(TIMEOUT - 1));
`else
    assign wd_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= next_state;
    end

    // Next-state logic; abort outranks op_done, op_done outranks the watchdog
    always_comb begin
        next_state = state;
        err_set    = 1'b0;
        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (dec_legal) begin
                        next_state = S_SETUP;
                    end else begin
                        next_state = S_DRAIN;
                        err_set    = 1'b1;
                    end
                end
            end
            S_SETUP: begin
                if (abort) begin
                    next_state = S_DRAIN;
                    err_set    = 1'b1;
                end else begin
                    next_state = S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    next_state = S_DRAIN;
                    err_set    = 1'b1;
                end else if (op_done) begin
                    next_state = S_DRAIN;
                end else if (wd_hit) begin
                    next_state = S_DRAIN;
                    err_set    = 1'b1;
                end
            end
            S_DRAIN: next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Registered outputs derived from the upcoming state so they align with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q              <= '0;
            server_counter_start <= 1'b0;
            seq_done             <= 1'b0;
            seq_err              <= 1'b0;
        end else begin
            if (state == S_IDLE && next_state == S_SETUP)
                flags_q <= dec_flags;
            else if (next_state == S_IDLE)
                flags_q <= '0;
            server_counter_start <= (next_state == S_RUN);
            seq_done             <= (next_state == S_DRAIN);
            if (state == S_IDLE && cmd_valid)
                seq_err <= err_set;
            else if (err_set)
                seq_err <= 1'b1;
        end
    end

    assign cmd_ready = (state == S_IDLE);
    assign seq_busy  = (state != S_IDLE);

    assign decode_start       = flags_q[F_DECODE];
    assign accumulate_start   = flags_q[F_ACCUM];
    assign decrypt_start      = flags_q[F_DECRYPT];
    assign no_ntt             = flags_q[F_NO_NTT];
    assign mem_pk_sk_transfer = flags_q[F_PK_SK];
    assign mem_sk_pk_transfer = flags_q[F_SK_PK];
    assign ep_accumulate      = flags_q[F_EP_ACC];
    assign ep_gen             = flags_q[F_EP_GEN];
    assign extr_mul           = flags_q[F_EXTR_MUL];
    assign intt_start         = flags_q[F_INTT];
    assign ntt_start_out      = flags_q[F_NTT];

endmodule

// File: tb/tb_server_op_sequencer.sv
// Self-checking bench for server_op_sequencer: a behavioural counter produces
// op_done, expected completions go through a scoreboard queue, and the
// start/flag outputs are compared every cycle against expected windows.
module tb_server_op_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cmd_valid = 1'b0;
    logic [3:0] cmd_op = 4'd0;
    logic cmd_ready;
    logic abort = 1'b0;
    logic op_done;
    logic server_counter_start;
    logic decode_start, accumulate_start, decrypt_start, no_ntt;
    logic mem_pk_sk_transfer, mem_sk_pk_transfer, ep_accumulate, ep_gen;
    logic extr_mul, intt_start, ntt_start_out;
    logic seq_busy, seq_done, seq_err;

    server_op_sequencer #(.TO_W(10), .TIMEOUT(1000)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .cmd_valid            (cmd_valid),
        .cmd_op               (cmd_op),
        .cmd_ready            (cmd_ready),
        .abort                (abort),
        .op_done              (op_done),
        .server_counter_start (server_counter_start),
        .decode_start         (decode_start),
        .accumulate_start     (accumulate_start),
        .decrypt_start        (decrypt_start),
        .no_ntt               (no_ntt),
        .mem_pk_sk_transfer   (mem_pk_sk_transfer),
        .mem_sk_pk_transfer   (mem_sk_pk_transfer),
        .ep_accumulate        (ep_accumulate),
        .ep_gen               (ep_gen),
        .extr_mul             (extr_mul),
        .intt_start           (intt_start),
        .ntt_start_out        (ntt_start_out),
        .seq_busy             (seq_busy),
        .seq_done             (seq_done),
        .seq_err              (seq_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int done_cyc;
        int err;
    } sb_t;

    sb_t sb[$];
    sb_t sb_e;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int cnt    = 0;
    int n_cur  = 0;
    int win_lo = 1, win_hi = 0;
    int flo    = 1, fhi    = 0;
    int fexp   = 0;
    bit chk_en = 1'b0;

    logic [10:0] flags_obs;
    assign flags_obs = {ntt_start_out, intt_start, extr_mul, ep_gen, ep_accumulate,
                        mem_sk_pk_transfer, mem_pk_sk_transfer, no_ntt, decrypt_start,
                        accumulate_start, decode_start};

    // Behavioural server counter: cleared while start is low, counts while high
    always @(posedge clk) begin
        if (!server_counter_start) cnt <= 0;
        else                       cnt <= cnt + 1;
        cyc <= cyc + 1;
    end
    assign op_done = server_counter_start && (cnt == n_cur);

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int exp_flags(input int op);
        case (op)
            0:       return 11'h001;
            1:       return 11'h002;
            2:       return 11'h00C;
            3:       return 11'h010;
            4:       return 11'h020;
            5:       return 11'h0C0;
            6:       return 11'h080;
            7:       return 11'h100;
            8:       return 11'h200;
            9:       return 11'h400;
            default: return 0;
        endcase
    endfunction

    // Per-cycle output checks and scoreboard pop on each completion pulse
    always @(negedge clk) begin
        if (chk_en) begin
            chk("start", server_counter_start, (cyc >= win_lo && cyc <= win_hi) ? 1 : 0);
            chk("flags", flags_obs, (cyc >= flo && cyc <= fhi) ? fexp : 0);
            if (seq_done) begin
                if (sb.size() == 0) begin
                    chk("spurious_done", 1, 0);
                end else begin
                    sb_e = sb.pop_front();
                    chk("done_cycle", cyc, sb_e.done_cyc);
                    chk("done_err", seq_err, sb_e.err);
                end
            end
        end
    end

    task automatic issue(input int op, input int n, input bit legal, output int acc);
        @(negedge clk);
        for (int i = 0; i < 3000 && !cmd_ready; i++) @(negedge clk);
        if (!cmd_ready) begin
            chk("ready_wait", cmd_ready, 1);
            acc = -1;
            return;
        end
        cmd_valid = 1'b1;
        cmd_op    = 4'(op);
        acc       = cyc;
        n_cur     = n;
        if (legal) begin
            win_lo = acc + 2;  win_hi = acc + n + 2;
            flo    = acc + 1;  fhi    = acc + n + 3;
            fexp   = exp_flags(op);
            sb.push_back('{acc + n + 3, 0});
        end else begin
            win_lo = 1; win_hi = 0;
            flo    = 1; fhi    = 0;
            fexp   = 0;
            sb.push_back('{acc + 1, 1});
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 3000 && (sb.size() != 0 || !cmd_ready); i++) @(negedge clk);
        chk("drain_wait", sb.size(), 0);
    endtask

    task automatic wait_cycle(input int target);
        for (int i = 0; i < 3000 && cyc < target; i++) @(negedge clk);
        chk("reach_cycle", cyc, target);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_flags"}, flags_obs, 0);
        chk({tag, "_start"}, server_counter_start, 0);
        chk({tag, "_done"},  seq_done, 0);
        chk({tag, "_err"},   seq_err, 0);
        chk({tag, "_busy"},  seq_busy, 0);
        chk({tag, "_ready"}, cmd_ready, 1);
    endtask

    initial begin
        #2ms;
        $display("FAIL global_timeout: got stuck expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        int a, a2;
        int more_ops [6] = '{2, 3, 4, 5, 6, 10};
        int more_n   [6] = '{65, 576, 131, 99, 99, 64};

        // Reset state
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        @(negedge clk);
        chk_en = 1'b1;

        // DECODE, with a command offered while busy that must be ignored
        issue(0, 64, 1'b1, a);
        wait_cycle(a + 10);
        cmd_valid = 1'b1; cmd_op = 4'd1;
        repeat (5) @(negedge clk);
        cmd_valid = 1'b0;
        wait_idle();
        chk("decode_ready_back", cyc >= a + 68 ? 1 : 0, 1);

        // INTT then NTT back-to-back
        issue(8, 199, 1'b1, a);
        issue(9, 198, 1'b1, a2);
        chk("b2b_accept", a2, a + 203);
        wait_idle();

        // abort in IDLE is ignored
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        chk("idle_abort_busy", seq_busy, 0);

        // Illegal opcode, sticky error, cleared by the next accepted command
        issue(13, 0, 1'b0, a);
        wait_idle();
        chk("err_sticky", seq_err, 1);
        issue(2, 65, 1'b1, a);
        chk("err_clear", seq_err, 0);
        wait_idle();

        // Abort during RUN of ACCUM at counter value 300
        issue(1, 643, 1'b1, a);
        wait_cycle(a + 302);
        chk("abort_cnt", cnt, 300);
        win_hi = a + 302;
        fhi    = a + 303;
        sb[sb.size() - 1] = '{a + 303, 1};
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        wait_idle();

        // Remaining opcodes
        for (int k = 0; k < 6; k++) begin
            issue(more_ops[k], more_n[k], 1'b1, a);
            wait_idle();
        end

`ifdef SEQ_TIMEOUT_EN
        // Watchdog with op_done never reached
        issue(6, 4000, 1'b1, a);
        win_hi = a + 1001;
        fhi    = a + 1002;
        sb[sb.size() - 1] = '{a + 1002, 1};
        wait_idle();
`endif

        // Asynchronous reset in the middle of EXTR_MUL
        issue(7, 583, 1'b1, a);
        wait_cycle(a + 100);
        chk("mid_start", server_counter_start, 1);
        chk_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        sb.delete();
        win_lo = 1; win_hi = 0; flo = 1; fhi = 0; fexp = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", cmd_ready, 1);
        chk_en = 1'b1;

        // A normal command still works after the reset
        issue(0, 64, 1'b1, a);
        wait_idle();

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/server_op_sequencer.md
# server_op_sequencer

Command-driven FSM that sequences the server-side counter/address generator one operation at a time. Accepts an opcode over a valid/ready handshake, drives the matching one-hot operation flags, clears and releases `server_counter_start`, waits for `op_done`, then reports completion. It sits between the top-level protocol controller and the counter that drives the NTT/multiplier memories.

## Interface
- `TO_W`, 10: width of the watchdog counter.
- `TIMEOUT`, 1000: RUN cycles allowed before the watchdog aborts. Must exceed the longest terminal count, 643.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `cmd_valid`  in  1  opcode offered.
- `cmd_op`  in  4  opcode; encoding in Structure.
- `cmd_ready`  out  1  high only in IDLE.
- `abort`  in  1  synchronous abort of the current operation.
- `op_done`  in  1  terminal-count indication from the counter.
- `server_counter_start`  out  1  active-high run; low level clears the counter.
- `decode_start`, `accumulate_start`, `decrypt_start`, `no_ntt`, `mem_pk_sk_transfer`, `mem_sk_pk_transfer`, `ep_accumulate`, `ep_gen`, `extr_mul`, `intt_start`, `ntt_start_out`  out  1 each  operation flags.
- `seq_busy`  out  1  state is not IDLE.
- `seq_done`  out  1  one-cycle completion pulse.
- `seq_err`  out  1  sticky error; cleared on the next accepted command.

## Operation
- States: IDLE, SETUP, RUN, DRAIN.
- **IDLE**
  - `cmd_ready`=1.
  - On `cmd_valid`, the opcode is latched.
  - Legal opcode goes to SETUP. Illegal opcode (11–15) goes to DRAIN with `seq_err` set and no flags driven.
- **SETUP** (1 cycle)
  - Flags are driven from the latched opcode. `server_counter_start`=0.
  - `op_done` is ignored here, because the fallback path may assert it spuriously.
- **RUN**
  - `server_counter_start`=1 and flags are held.
  - `op_done` sampled high goes to DRAIN.
  - `abort` goes to DRAIN and sets `seq_err`. Abort wins if it coincides with `op_done`.
- **DRAIN** (1 cycle)
  - `server_counter_start`=0 and flags are held.
  - `seq_done`=1. Next state is IDLE, where the flags clear.
- `abort` in SETUP also goes to DRAIN with `seq_err`. `abort` in IDLE or DRAIN is ignored.
- All flag outputs are registered. Flags change only on entry to SETUP or IDLE, never while `server_counter_start`=1.
- A command offered during busy is held off by `cmd_ready`=0. There is no queueing.

## Timing
- Reset values:
  - All flags, `server_counter_start`, `seq_busy`, `seq_done` and `seq_err` are 0.
  - `cmd_ready`=1 and state is IDLE.
- Let A be the accept cycle. Then SETUP is A+1, the first RUN cycle is A+2, and the counter reads k in cycle A+2+k.
- For a terminal count N, DRAIN and `seq_done` fall in cycle A+N+3. IDLE and `cmd_ready` return in A+N+4.
- Back-to-back commands take at least N+4 cycles each.
- `server_counter_start` is low for at least 2 cycles between operations (DRAIN, then IDLE or SETUP), which guarantees the counter clears.
- Reset mid-operation: all outputs return to reset values immediately. `server_counter_start` falling asynchronously also clears the counter.

## Configuration
- `SEQ_TIMEOUT_EN` defined:
  - A `TO_W`-bit watchdog clears on entry to RUN and increments each RUN cycle.
  - On reaching `TIMEOUT` without `op_done`, the FSM goes to DRAIN, `seq_err`=1, and `seq_done` pulses.
- Undefined:
  - No watchdog is built and RUN waits indefinitely.
  - `seq_err` is set only by an illegal opcode or `abort`.

## Structure
- Package `server_seq_pkg` holds:
  - opcode enum: 0 DECODE, 1 ACCUM, 2 DECRYPT (`decrypt_start`+`no_ntt`), 3 PK_SK, 4 SK_PK, 5 EP_ACC (`ep_accumulate`+`ep_gen`), 6 EP_GEN, 7 EXTR_MUL, 8 INTT, 9 NTT (`ntt_start_out`), 10 KEYGEN (all flags low);
  - state enum;
  - terminal counts 64, 643, 65, 576, 131, 99, 583, 199, 198 for benches.
- One sub-module, `server_op_decode`: combinational opcode to 11-bit flag vector, registered in the parent.

## Test plan
- DECODE accepted at A → `seq_done` at A+67. `server_counter_start` is high over A+2..A+66 and flags stay constant throughout.
- INTT then NTT back-to-back → `seq_done` at A+202, second accept at A+203, `server_counter_start` low over A+202..A+204, second `seq_done` at A+203+201.
- Opcode 13 → no flags or `server_counter_start`, `seq_done`+`seq_err` at A+1. The next valid command clears `seq_err`.
- `abort` in RUN at counter=300 of ACCUM → DRAIN next cycle, `seq_err`=1, flags clear a cycle later.
- `SEQ_TIMEOUT_EN`, TIMEOUT=1000, `op_done` tied low → `seq_done`+`seq_err` exactly 1000 RUN cycles after first RUN.
- `rst_n` asserted mid-EXTR_MUL → all outputs 0 asynchronously, `cmd_ready`=1 after release.
